// File: rtl/uart_cmd_pkg.sv
// Shared types and byte codes for the UART command responder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;

  // True for the two opcodes that start a real frame.
  function automatic logic is_command(input logic [7:0] b);
    return (b == CmdWrite) || (b == CmdRead);
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses W/R command frames from the UART RX byte stream, performs one access
// on the register bus and returns ACK/NAK (plus read data) over the TX handshake.
// AddrWidth and DataWidth must be multiples of 8; multi-byte fields travel MSB first.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int AddrWidth         = 16,
  parameter int DataWidth         = 32,
  parameter int ByteTimeoutCycles = 500000,
  parameter int BusTimeoutCycles  = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 rx_error_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  output logic                 bus_we_o,
  output logic                 bus_req_o,
  input  logic [DataWidth-1:0] bus_rdata_i,
  input  logic                 bus_ack_i,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int AddrBytes = AddrWidth / 8;
  localparam int DataBytes = DataWidth / 8;
  localparam int RespW     = DataWidth + 8;

  localparam logic [7:0] AddrLast    = 8'(AddrBytes - 1);
  localparam logic [7:0] DataLast    = 8'(DataBytes - 1);
  localparam logic [7:0] RespReadCnt = 8'(DataBytes + 1);

  localparam int ByteTmrW = $clog2(ByteTimeoutCycles + 1);
  localparam int BusTmrW  = $clog2(BusTimeoutCycles + 1);
  localparam logic [ByteTmrW-1:0] ByteTmrLast = ByteTmrW'(ByteTimeoutCycles - 1);
  localparam logic [BusTmrW-1:0]  BusTmrLast  = BusTmrW'(BusTimeoutCycles - 1);

  state_t state;
  state_t state_next;

  logic [7:0]          byte_cnt;
  logic [ByteTmrW-1:0] byte_timer;
  logic [BusTmrW-1:0]  bus_timer;
  logic [RespW-1:0]    resp_shift;
  logic [7:0]          resp_left;
  logic                is_write;

  logic load_nak;
  logic take_byte;

  assign busy_o    = (state != IDLE);
  assign tx_data_o = resp_shift[RespW-1 -: 8];

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes the datapath needs (NAK load, field byte accepted).
  always_comb begin
    state_next = state;
    load_nak   = 1'b0;
    take_byte  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if (!rx_error_i && is_command(rx_data_i)) begin
            state_next = ADDR;
          end else begin
            state_next = RESP;
            load_nak   = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid_i) begin
          if (rx_error_i) begin
            state_next = RESP;
            load_nak   = 1'b1;
          end else begin
            take_byte = 1'b1;
            if (byte_cnt == AddrLast) begin
              state_next = is_write ? WDATA : BUS;
            end
          end
        end else if (byte_timer == ByteTmrLast) begin
          state_next = IDLE;
        end
      end
      WDATA: begin
        if (rx_valid_i) begin
          if (rx_error_i) begin
            state_next = RESP;
            load_nak   = 1'b1;
          end else begin
            take_byte = 1'b1;
            if (byte_cnt == DataLast) begin
              state_next = BUS;
            end
          end
        end else if (byte_timer == ByteTmrLast) begin
          state_next = IDLE;
        end
      end
      BUS: begin
        if (bus_req_o && bus_ack_i) begin
          state_next = RESP;
        end else if (bus_req_o && (bus_timer == BusTmrLast)) begin
          state_next = RESP;
          load_nak   = 1'b1;
        end
      end
      RESP: begin
        if (tx_valid_o && tx_ready_i && (resp_left == 8'd1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: field shifting, timeout counters, bus request and the response shifter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_cnt    <= '0;
      byte_timer  <= '0;
      bus_timer   <= '0;
      resp_shift  <= '0;
      resp_left   <= '0;
      is_write    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_we_o    <= 1'b0;
      bus_req_o   <= 1'b0;
      tx_valid_o  <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= rx_valid_i && ((state == BUS) || (state == RESP));

      if ((state == ADDR) || (state == WDATA)) begin
        if (take_byte) begin
          byte_timer <= '0;
        end else begin
          byte_timer <= byte_timer + ByteTmrW'(1);
        end
      end else begin
        byte_timer <= '0;
      end

      if (take_byte) begin
        byte_cnt <= (state_next != state) ? 8'd0 : byte_cnt + 8'd1;
      end else if (state == IDLE) begin
        byte_cnt <= 8'd0;
      end

      if ((state == IDLE) && rx_valid_i && !rx_error_i) begin
        is_write <= (rx_data_i == CmdWrite);
      end

      if (take_byte && (state == ADDR)) begin
        bus_addr_o <= (bus_addr_o << 8) | AddrWidth'(rx_data_i);
      end
      if (take_byte && (state == WDATA)) begin
        bus_wdata_o <= (bus_wdata_o << 8) | DataWidth'(rx_data_i);
      end

      if (state == BUS) begin
        if (!bus_req_o) begin
          bus_req_o <= 1'b1;
          bus_we_o  <= is_write;
          bus_timer <= '0;
        end else if (bus_ack_i) begin
          bus_req_o <= 1'b0;
          bus_we_o  <= 1'b0;
          if (is_write) begin
            resp_shift <= {RspAck, {DataWidth{1'b0}}};
            resp_left  <= 8'd1;
          end else begin
            resp_shift <= {RspAck, bus_rdata_i};
            resp_left  <= RespReadCnt;
          end
        end else if (bus_timer == BusTmrLast) begin
          bus_req_o <= 1'b0;
          bus_we_o  <= 1'b0;
        end else begin
          bus_timer <= bus_timer + BusTmrW'(1);
        end
      end

      if (load_nak) begin
        resp_shift <= {RspNak, {DataWidth{1'b0}}};
        resp_left  <= 8'd1;
      end

      if (state == RESP) begin
        if (tx_valid_o && tx_ready_i) begin
          tx_valid_o <= 1'b0;
          resp_shift <= {resp_shift[RespW-9:0], 8'h00};
          resp_left  <= resp_left - 8'd1;
        end else if (!tx_valid_o && (resp_left != 8'd0)) begin
          tx_valid_o <= 1'b1;
        end
      end else begin
        tx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed self-checking bench for uart_cmd_responder with a small bus responder model.
module tb_uart_cmd_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_error_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_we_o;
  logic        bus_req_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        busy_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  txq[$];
  int          acc_count  = 0;
  int          req_cycles = 0;
  int          ovr_count  = 0;
  logic [15:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;
  logic        last_we    = 1'b0;

  bit   ready_random = 1'b1;
  logic ready_fixed  = 1'b1;
  bit   ack_en       = 1'b1;
  int   ack_delay    = 3;
  int   req_seen     = 0;

  always #5 clk_i = ~clk_i;

  uart_cmd_responder #(
    .AddrWidth(16),
    .DataWidth(32),
    .ByteTimeoutCycles(200),
    .BusTimeoutCycles(64)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_error_i(rx_error_i),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o),
    .bus_req_o(bus_req_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i),
    .busy_o(busy_o),
    .overrun_o(overrun_o)
  );

  // Records transmitted bytes, completed bus accesses, request cycles and overrun pulses.
  always @(posedge clk_i) begin
    if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    if (bus_req_o) req_cycles++;
    if (bus_req_o && bus_ack_i) begin
      acc_count++;
      last_addr  = bus_addr_o;
      last_wdata = bus_wdata_o;
      last_we    = bus_we_o;
    end
    if (overrun_o) ovr_count++;
  end

  // Transmitter readiness: random or held at a fixed level.
  initial begin
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      tx_ready_i = ready_random ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Bus slave: acks in the ack_delay-th cycle of a request unless disabled.
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'hCAFEF00D;
    forever begin
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      if (bus_req_o) begin
        req_seen++;
        if (ack_en && (req_seen == ack_delay)) bus_ack_i = 1'b1;
      end else begin
        req_seen = 0;
      end
    end
  end

  // Hard stop in case something below fails to bound itself.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic err);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    rx_error_i = err;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    rx_error_i = 1'b0;
  endtask

  task automatic sendFrame(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(v[i*8 +: 8], 1'b0);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy_o === 1'b1) && (n < budget)) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(tag, 64'(busy_o), 64'd0);
  endtask

  function automatic logic [63:0] packTx();
    logic [63:0] r;
    r = '0;
    foreach (txq[i]) r = (r << 8) | 64'(txq[i]);
    return r;
  endfunction

  initial begin
    int n;
    int bad;
    int rc;
    int ac;
    int oc;

    reset_i    = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    rx_error_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_tx_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_bus_req", 64'(bus_req_o), 64'd0);
    checkOutput("reset_bus_addr", 64'(bus_addr_o), 64'd0);
    checkOutput("reset_bus_wdata", 64'(bus_wdata_o), 64'd0);
    checkOutput("reset_overrun", 64'(overrun_o), 64'd0);
    reset_i = 1'b0;

    $display("[TB] write frame");
    txq.delete();
    sendFrame(64'h57_1234_DEADBEEF, 7);
    waitIdle("write_idle", 300);
    checkOutput("write_acc_count", 64'(acc_count), 64'd1);
    checkOutput("write_addr", 64'(last_addr), 64'h1234);
    checkOutput("write_wdata", 64'(last_wdata), 64'hDEADBEEF);
    checkOutput("write_we", 64'(last_we), 64'd1);
    checkOutput("write_tx_count", 64'(txq.size()), 64'd1);
    checkOutput("write_tx_bytes", packTx(), 64'h06);
    checkOutput("write_addr_hold", 64'(bus_addr_o), 64'h1234);

    $display("[TB] read frame with held tx_ready");
    txq.delete();
    ready_random = 1'b0;
    ready_fixed  = 1'b0;
    sendFrame(64'h52_0010, 3);
    n = 0;
    while ((tx_valid_o !== 1'b1) && (n < 100)) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("read_first_valid", 64'(tx_valid_o), 64'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk_i);
      if ((tx_valid_o !== 1'b1) || (tx_data_o !== 8'h06)) bad++;
    end
    checkOutput("read_tx_hold", 64'(bad), 64'd0);
    checkOutput("read_none_while_held", 64'(txq.size()), 64'd0);
    ready_random = 1'b1;
    waitIdle("read_idle", 300);
    checkOutput("read_tx_count", 64'(txq.size()), 64'd5);
    checkOutput("read_tx_bytes", packTx(), 64'h06CAFEF00D);
    checkOutput("read_acc_count", 64'(acc_count), 64'd2);
    checkOutput("read_we", 64'(last_we), 64'd0);
    checkOutput("read_addr", 64'(last_addr), 64'h0010);

    $display("[TB] bad command");
    txq.delete();
    ac = acc_count;
    sendFrame(64'h41, 1);
    waitIdle("badcmd_idle", 100);
    checkOutput("badcmd_tx_count", 64'(txq.size()), 64'd1);
    checkOutput("badcmd_tx_bytes", packTx(), 64'h15);
    checkOutput("badcmd_no_access", 64'(acc_count - ac), 64'd0);

    $display("[TB] rx error mid-frame");
    txq.delete();
    rc = req_cycles;
    applyStimulus(8'h57, 1'b0);
    applyStimulus(8'h12, 1'b1);
    waitIdle("rxerr_idle", 100);
    checkOutput("rxerr_tx_bytes", packTx(), 64'h15);
    checkOutput("rxerr_tx_count", 64'(txq.size()), 64'd1);
    checkOutput("rxerr_no_req", 64'(req_cycles - rc), 64'd0);

    $display("[TB] byte timeout");
    txq.delete();
    sendFrame(64'h52_00, 2);
    checkOutput("bto_busy_before", 64'(busy_o), 64'd1);
    repeat (220) @(negedge clk_i);
    checkOutput("bto_idle", 64'(busy_o), 64'd0);
    checkOutput("bto_no_tx", 64'(txq.size()), 64'd0);
    sendFrame(64'h52_0020, 3);
    waitIdle("bto_next_idle", 300);
    checkOutput("bto_next_tx_bytes", packTx(), 64'h06CAFEF00D);
    checkOutput("bto_next_addr", 64'(last_addr), 64'h0020);

    $display("[TB] bus timeout");
    txq.delete();
    ack_en = 1'b0;
    rc = req_cycles;
    ac = acc_count;
    sendFrame(64'h52_0030, 3);
    waitIdle("busto_idle", 400);
    ack_en = 1'b1;
    checkOutput("busto_tx_count", 64'(txq.size()), 64'd1);
    checkOutput("busto_tx_bytes", packTx(), 64'h15);
    checkOutput("busto_req_cycles", 64'(req_cycles - rc), 64'd64);
    checkOutput("busto_no_access", 64'(acc_count - ac), 64'd0);

    $display("[TB] overrun during bus access");
    txq.delete();
    ack_delay = 10;
    oc = ovr_count;
    sendFrame(64'h52_0040, 3);
    n = 0;
    while ((bus_req_o !== 1'b1) && (n < 20)) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("ovr_in_bus", 64'(bus_req_o), 64'd1);
    applyStimulus(8'h99, 1'b0);
    waitIdle("ovr_idle", 300);
    ack_delay = 3;
    checkOutput("ovr_pulses", 64'(ovr_count - oc), 64'd1);
    checkOutput("ovr_tx_bytes", packTx(), 64'h06CAFEF00D);

    $display("[TB] reset during response");
    txq.delete();
    sendFrame(64'h52_0050, 3);
    n = 0;
    while ((txq.size() < 2) && (n < 300)) begin
      @(negedge clk_i);
      n++;
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_tx_count", 64'(txq.size()), 64'd2);
    reset_i = 1'b0;
    txq.delete();
    sendFrame(64'h57_ABCD_01234567, 7);
    waitIdle("rst_next_idle", 300);
    checkOutput("rst_next_tx_bytes", packTx(), 64'h06);
    checkOutput("rst_next_addr", 64'(last_addr), 64'hABCD);
    checkOutput("rst_next_wdata", 64'(last_wdata), 64'h01234567);
    checkOutput("rst_next_we", 64'(last_we), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
